data_mem_responder: RTL and testbench

Word-addressed data memory that serves the load/store traffic issued by the core's control path: it is the responding end of the MemWrite / ResultSrc memory interface. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It returns read data or a write acknowledgement with a one-cycle response pulse. It sits between the ALU result and write-data path and the result multiplexer, and lets the core stall on a non-zero-latency memory.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_array.sv | 47 ++++
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: FSM states, the load/store
// opcodes used by the control path, and the data word width.
package dmem_pkg;

    localparam int WORD_W = 32;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Word storage for the data memory responder. The write is synchronous, with
// per-byte lane enables. The read data is registered on the commit edge and is
// cleared in every other cycle, so it is non-zero only while a load response
// is being presented. The storage itself is never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic                           wr_en,
    input  logic [WORD_W-1:0]              wdata,
    input  logic [3:0]                     wstrb,
    input  logic                           rd_en,
    output logic [WORD_W-1:0]              rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Byte-lane store into the array (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (wstrb[lane]) begin
                    mem_q[idx][8*lane +: 8] <= wdata[8*lane +: 8];
                end
            end
        end
    end

    // Registered read port: capture the word on the commit edge, zero otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else if (rd_en) begin
            rdata_q <= mem_q[idx];
        end else begin
            rdata_q <= 32'd0;
        end
    end

    assign rdata = rdata_q;

endmodule : dmem_array

// File: rtl/data_mem_responder.sv
// Responding end of the core's load/store interface. It accepts one request at a
// time, waits WAIT_CYCLES cycles, then returns a one-cycle response with the load
// data or a fault flag.
// Optional build macro DMEM_BYTE_EN adds the req_wstrb port for byte-lane stores.
// Without the macro, every good store writes the full word.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [3:0]        req_wstrb,
`endif
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [3:0]        strb_q, strb_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              req_ready_q, req_ready_d;

    logic [3:0]        strb_in;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [3:0]        cur_strb;
    logic              commit;
    logic              fault;
    logic              wr_en;
    logic              rd_en;

`ifdef DMEM_BYTE_EN
    assign strb_in = req_wstrb;
`else
    assign strb_in = 4'hF;
`endif

    // With zero wait states, the commit edge is the accept edge. Use the live
    // request in IDLE and the latched copy in every other state.
    assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_strb  = (state_q == IDLE) ? strb_in   : strb_q;

    // State, counter, request latch and registered outputs; reset wins over all
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            strb_q      <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Next state: accept in IDLE, count down wait states, single RESP cycle
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    strb_d     = strb_in;
                    wait_cnt_d = 4'(WAIT_CYCLES);
                    state_d    = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    // Outputs: fault check, memory enables and next values of the response flops
    always_comb begin
        commit      = (state_d == RESP);
        fault       = (cur_addr[1:0] != 2'b00) ||
                      ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
        wr_en       = commit && cur_we && !fault && !rst;
        rd_en       = commit && !cur_we && !fault;
        rsp_valid_d = commit;
        rsp_err_d   = commit && fault;
        req_ready_d = (state_d == IDLE);
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .idx  (cur_addr[AW+1:2]),
        .wr_en(wr_en),
        .wdata(cur_wdata),
        .wstrb(cur_strb),
        .rd_en(rd_en),
        .rdata(rsp_rdata)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign req_ready = req_ready_q;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder.
// Instance 0 uses two wait states and instance 1 uses zero wait states.
// A word-array reference model predicts every response.
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int W0    = 2;
    localparam int W1    = 0;

    logic        clk;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    logic [31:0] ref_mem [2][DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef DMEM_BYTE_EN
        .req_wstrb(req_wstrb[0]),
`endif
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef DMEM_BYTE_EN
        .req_wstrb(req_wstrb[1]),
`endif
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete request/response transaction, checked against the model
    task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb, input bit toggle);
        int          w;
        int          n;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  eff_strb;
        w = (d == 0) ? W0 : W1;
`ifdef DMEM_BYTE_EN
        eff_strb = strb;
`else
        eff_strb = 4'hF;
`endif
        exp_err   = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
        idx       = exp_err ? 0 : int'(addr / 4);
        exp_rdata = (!we && !exp_err) ? ref_mem[d][idx] : 32'd0;

        check_val("ready_idle", {31'd0, req_ready[d]}, 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wstrb[d] = strb;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        check_val("ready_busy", {31'd0, req_ready[d]}, 32'd0);
        n = 0;
        while (rsp_valid[d] !== 1'b1 && n < 40) begin
            if (toggle) begin
                req_valid[d] = 1'($urandom_range(0, 1));
                req_addr[d]  = $urandom;
                req_we[d]    = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            n++;
        end
        req_valid[d] = 1'b0;
        check_val("latency", n, w);
        check_val("rdata", rsp_rdata[d], exp_rdata);
        check_val("err", {31'd0, rsp_err[d]}, {31'd0, exp_err});
        check_val("ready_resp", {31'd0, req_ready[d]}, 32'd0);
        @(posedge clk);
        #1;
        check_val("rsp_one_cycle", {31'd0, rsp_valid[d]}, 32'd0);
        check_val("ready_back", {31'd0, req_ready[d]}, 32'd1);
        if (we && !exp_err) begin
            for (int i = 0; i < 4; i++) begin
                if (eff_strb[i]) ref_mem[d][idx][8*i +: 8] = wdata[8*i +: 8];
            end
        end
    endtask

    // Store interrupted by reset after 'ed' edges of pending request; must not commit
    task automatic rst_mid(input int d, input logic [31:0] addr, input logic [31:0] wdata, input int ed);
        bit seen;
        seen = 1'b0;
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b1;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wstrb[d] = 4'hF;
        for (int k = 0; k < ed; k++) begin
            @(posedge clk);
            #1;
            req_valid[d] = 1'b0;
            if (rsp_valid[d] === 1'b1) seen = 1'b1;
        end
        rst[d] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            req_valid[d] = 1'b0;
            if (rsp_valid[d] === 1'b1) seen = 1'b1;
        end
        rst[d] = 1'b0;
        check_val("rst_no_rsp", {31'd0, seen}, 32'd0);
        check_val("rst_ready", {31'd0, req_ready[d]}, 32'd1);
        check_val("rst_rdata", rsp_rdata[d], 32'd0);
        check_val("rst_err", {31'd0, rsp_err[d]}, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
        else if (r == 1) return 32'(DEPTH * 4 + $urandom_range(0, 1000) * 4);
        else if (r == 2) return {1'b1, 31'($urandom)};
        else return 32'($urandom_range(0, DEPTH - 1) * 4);
    endfunction

    // Main stimulus sequence
    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; req_wstrb[d] = 4'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val("reset_ready", {31'd0, req_ready[d]}, 32'd1);
            check_val("reset_valid", {31'd0, rsp_valid[d]}, 32'd0);
            check_val("reset_rdata", rsp_rdata[d], 32'd0);
            check_val("reset_err", {31'd0, rsp_err[d]}, 32'd0);
            rst[d] = 1'b0;
        end

        // Fill both memories so every model word is known
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                do_req(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);

        // Store then load, two wait states
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        check_val("model_deadbeef", ref_mem[0][4], 32'hDEADBEEF);

        // Zero wait states
        do_req(1, 1'b1, 32'h0, 32'h12345678, 4'hF, 1'b0);
        do_req(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);

        // Faults leave the addressed words untouched
        do_req(0, 1'b1, 32'h11, 32'h55555555, 4'hF, 1'b0);
        do_req(0, 1'b1, 32'(DEPTH * 4), 32'h66666666, 4'hF, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        do_req(1, 1'b1, 32'h11, 32'h55555555, 4'hF, 1'b0);
        do_req(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);

`ifdef DMEM_BYTE_EN
        // Byte lane stores
        do_req(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1'b0);
        do_req(0, 1'b1, 32'h20, 32'h000000AB, 4'b0001, 1'b0);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
        check_val("model_strobe", ref_mem[0][8], 32'hFFFFFFAB);
`endif

        // Reset during WAIT, on the commit edge, and on the zero-wait commit edge
        do_req(0, 1'b1, 32'h40, 32'h11111111, 4'hF, 1'b0);
        rst_mid(0, 32'h40, 32'hCAFEF00D, 1);
        do_req(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
        rst_mid(0, 32'h40, 32'hCAFEF00D, 2);
        do_req(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
        do_req(1, 1'b1, 32'h40, 32'h11111111, 4'hF, 1'b0);
        rst_mid(1, 32'h40, 32'hCAFEF00D, 0);
        do_req(1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);

        // Inputs toggled while waiting are ignored
        do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        do_req(0, 1'b1, 32'h14, 32'hA5A5A5A5, 4'hF, 1'b1);
        do_req(0, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            int d;
            d = $urandom_range(0, 1);
            do_req(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_data_mem_responder
